// File: rtl/inv_round_key_buffer_pkg.sv
// Shared AES definitions used by the inverse round-key buffer and its
// neighbouring AES blocks: Algorithm encodings, round counts, the buffer
// state encoding and the round-key slot count.
package inv_round_key_buffer_pkg;

   // Algorithm field encodings
   localparam logic [1:0] ALG_128  = 2'b00;
   localparam logic [1:0] ALG_256  = 2'b01;
   localparam logic [1:0] ALG_192  = 2'b10;
   localparam logic [1:0] ALG_RSVD = 2'b11;

   // Number of rounds per key size
   localparam logic [3:0] NR_128 = 4'd10;
   localparam logic [3:0] NR_192 = 4'd12;
   localparam logic [3:0] NR_256 = 4'd14;

   // Buffer controller states
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FILL  = 2'd1;
   localparam logic [1:0] ST_READY = 2'd2;

   // One slot per round key, rounds 0..14
   localparam int NUM_SLOTS = 15;
   localparam int SLOT_AW   = 4;
   localparam int RK_W      = 128;

   // Round count for an Algorithm code; the reserved code never reaches the
   // latched Algorithm, so its value here is only a safe default.
   function automatic logic [3:0] alg_to_nr(input logic [1:0] alg);
      case (alg)
         ALG_256: alg_to_nr = NR_256;
         ALG_192: alg_to_nr = NR_192;
         default: alg_to_nr = NR_128;
      endcase
   endfunction

endpackage

// File: rtl/inv_round_key_buffer_rk_store.sv
// rk_store: 15 x 128-bit round-key slot array with one write port and a
// registered, gated read port.
//   clk, rst        : clock, synchronous active-high reset (read register only)
//   we/waddr/wdata  : slot write
//   ren/raddr       : read enable and slot index; ren=0 yields zero data
//   rdata           : registered read data
module rk_store
   import inv_round_key_buffer_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               we,
   input  logic [SLOT_AW-1:0] waddr,
   input  logic [RK_W-1:0]    wdata,
   input  logic               ren,
   input  logic [SLOT_AW-1:0] raddr,
   output logic [RK_W-1:0]    rdata
);

   // Slot contents are never reset; the read gating hides stale data.
   logic [RK_W-1:0] mem_q [NUM_SLOTS];
   logic [RK_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst)      rdata_q <= '0;
      else if (ren) rdata_q <= mem_q[raddr];
      else          rdata_q <= '0;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/inv_round_key_buffer.sv
// inv_round_key_buffer: on start, latches the cipher key/Algorithm, steps
// the external inverse-key module through round indices 0..Nr, captures each
// returned round key into a slot, then serves registered slot reads.
//   clk, rst            : clock, synchronous active-high reset
//   start, key, Algorithm : fill request and its parameters
//   key_o, alg_o, i_o   : drive the external inverse-key module
//   rk_in               : round key returned for i_o (combinational)
//   busy, done, err, nr : fill status, done pulse, sticky reserved-alg flag, Nr
//   rd_idx, rd_key      : slot read index and registered read data
module inv_round_key_buffer
   import inv_round_key_buffer_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [255:0] key,
   input  logic [1:0]   Algorithm,
   output logic [255:0] key_o,
   output logic [1:0]   alg_o,
   output logic [3:0]   i_o,
   input  logic [127:0] rk_in,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic [3:0]   nr,
   input  logic [3:0]   rd_idx,
   output logic [127:0] rd_key
);

   logic [1:0]   state_q, state_d;
   logic [3:0]   i_q, i_d;
   logic [255:0] key_q, key_d;
   logic [1:0]   alg_q, alg_d;
   logic         done_q, done_d;
   logic         err_q, err_d;

   assign nr = alg_to_nr(alg_q);

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      key_d   = key_q;
      alg_d   = alg_q;
      done_d  = 1'b0;
      err_d   = err_q;
      case (state_q)
         ST_IDLE, ST_READY: begin
            if (start) begin
               if (Algorithm == ALG_RSVD) begin
                  // Leaving READY invalidates whatever the slots hold.
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  key_d   = key;
                  alg_d   = Algorithm;
                  i_d     = 4'd0;
                  err_d   = 1'b0;
                  state_d = ST_FILL;
               end
            end
         end
         ST_FILL: begin
            // start is deliberately not looked at here.
            if (i_q == nr) begin
               state_d = ST_READY;
               done_d  = 1'b1;
            end else begin
               i_d = i_q + 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         i_q     <= '0;
         key_q   <= '0;
         alg_q   <= ALG_128;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         key_q   <= key_d;
         alg_q   <= alg_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   rk_store u_store (
      .clk   (clk),
      .rst   (rst),
      .we    (state_q == ST_FILL),
      .waddr (i_q),
      .wdata (rk_in),
      .ren   ((state_q == ST_READY) && (rd_idx <= nr)),
      .raddr (rd_idx),
      .rdata (rd_key)
   );

   assign key_o = key_q;
   assign alg_o = alg_q;
   assign i_o   = i_q;
   assign busy  = (state_q == ST_FILL);
   assign done  = done_q;
   assign err   = err_q;

endmodule

// File: tb/tb_inv_round_key_buffer.sv
module tb_inv_round_key_buffer;

   logic         clk = 1'b0;
   logic         rst, start;
   logic [255:0] key;
   logic [1:0]   Algorithm;
   logic [255:0] key_o;
   logic [1:0]   alg_o;
   logic [3:0]   i_o;
   logic [127:0] rk_in;
   logic         busy, done, err;
   logic [3:0]   nr;
   logic [3:0]   rd_idx;
   logic [127:0] rd_key;

   int tests = 0;
   int fails = 0;

   // reference model: what the buffer should hold
   logic         m_ready;
   int           m_nr;
   logic [127:0] m_slot [15];

   logic [127:0] exp_q [$];
   logic         rd_req, rd_req_d;

   always #5 clk = ~clk;

   inv_round_key_buffer dut (
      .clk(clk), .rst(rst), .start(start), .key(key), .Algorithm(Algorithm),
      .key_o(key_o), .alg_o(alg_o), .i_o(i_o), .rk_in(rk_in),
      .busy(busy), .done(done), .err(err), .nr(nr),
      .rd_idx(rd_idx), .rd_key(rd_key)
   );

   // stand-in for the external inverse-key module: any distinct function of
   // (key, alg, i) works since the buffer only has to store what it is given
   function automatic logic [127:0] ext_rk(input logic [255:0] k, input logic [1:0] a,
                                           input logic [3:0] i);
      logic [7:0] tag;
      tag = {i, 2'b00, a};
      return k[255:128] ^ {k[126:0], k[127]} ^ {16{tag}};
   endfunction

   assign rk_in = ext_rk(key_o, alg_o, i_o);

   function automatic int nr_of(input logic [1:0] a);
      case (a)
         2'b00:   return 10;
         2'b01:   return 14;
         default: return 12;
      endcase
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // monitor: every read issued one cycle earlier is compared against the queue
   always @(posedge clk) rd_req_d <= rd_req;
   always @(negedge clk) begin
      if (rd_req_d) begin
         if (exp_q.size() == 0) chk("rd_key_noexp", 1'b1, 1'b0);
         else chk("rd_key", rd_key, exp_q.pop_front());
      end
   end

   task automatic issue_read(input logic [3:0] idx);
      rd_idx = idx;
      rd_req = 1'b1;
      if (m_ready && int'(idx) <= m_nr) exp_q.push_back(m_slot[idx]);
      else exp_q.push_back('0);
   endtask

   task automatic read_all();
      for (int i = 0; i < 16; i++) begin
         issue_read(4'(i));
         tick();
      end
      rd_req = 1'b0;
      tick();
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_i_o"}, i_o, 0);
      chk({tag, "_key_o"}, key_o[127:0] | key_o[255:128], 0);
      chk({tag, "_alg_o"}, alg_o, 0);
      chk({tag, "_rd_key"}, rd_key, 0);
   endtask

   // kind: 0 plain fill, 1 extra start at FILL cycle inj, 2 rst at FILL cycle inj
   task automatic run_fill(input logic [255:0] k, input logic [1:0] a,
                           input int inj, input int kind);
      int cnt = 0;
      int enr = nr_of(a);
      start = 1'b1; key = k; Algorithm = a;
      tick();
      start = 1'b0;
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      Algorithm = 2'($urandom_range(0, 3));
      m_ready = 1'b0;
      chk("err_after_start", err, 0);
      while (busy && cnt < 40) begin
         cnt++;
         issue_read(4'($urandom_range(0, 15)));
         if (cnt == inj && kind == 1) begin
            start = 1'b1; Algorithm = 2'b00;
         end
         if (cnt == inj && kind == 2) rst = 1'b1;
         tick();
         start = 1'b0;
         if (cnt == inj && kind == 2) begin
            rst = 1'b0;
            rd_req = 1'b0;
            check_reset_vals("rst_in_fill");
            for (int j = 0; j < 4; j++) begin
               tick();
               chk("no_done_after_rst", done, 0);
            end
            return;
         end
      end
      rd_req = 1'b0;
      chk("busy_cycles", cnt, enr + 1);
      chk("done_pulse", done, 1);
      chk("nr", nr, enr);
      chk("i_o_held", i_o, enr);
      m_ready = 1'b1;
      m_nr    = enr;
      for (int i = 0; i <= enr; i++) m_slot[i] = ext_rk(k, a, 4'(i));
      tick();
      chk("done_one_cycle", done, 0);
      chk("busy_after", busy, 0);
   endtask

   initial begin
      logic [255:0] k1;
      rst = 1'b1; start = 1'b0; key = '0; Algorithm = 2'b00;
      rd_idx = '0; rd_req = 1'b0; m_ready = 1'b0; m_nr = 0;
      tick(); tick();
      check_reset_vals("reset");
      chk("reset_nr", nr, 10);
      rst = 1'b0;
      tick();

      // AES-256 with the reference key
      k1 = 256'h4e5a6699_a9f24fe0_7e572baa_cdf8cdea_24fc79cc_bf0979e9_371ac23c_6d68de36;
      run_fill(k1, 2'b01, 0, 0);
      read_all();

      // AES-128 and AES-192
      run_fill({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 2'b00, 0, 0);
      read_all();
      run_fill({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 2'b10, 0, 0);
      read_all();

      // reserved Algorithm
      start = 1'b1; Algorithm = 2'b11; key = '1;
      tick();
      start = 1'b0;
      m_ready = 1'b0;
      chk("err_set", err, 1);
      for (int j = 0; j < 4; j++) begin
         chk("busy_on_rsvd", busy, 0);
         tick();
      end
      chk("err_sticky", err, 1);
      read_all();
      run_fill({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 2'b01, 0, 0);
      chk("err_cleared", err, 0);
      read_all();

      // start during FILL is ignored
      run_fill({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 2'b01, 5, 1);
      read_all();

      // reset in the middle of a fill
      run_fill({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 2'b00, 7, 2);
      read_all();

      // random refills straight from READY
      for (int r = 0; r < 6; r++) begin
         run_fill({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                  2'($urandom_range(0, 2)), 0, 0);
         read_all();
      end

      tick();
      chk("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
